csidh_limb_seq: RTL and testbench
=================================

Name: csidh_limb_seq

Overview:
- Multi-cycle sequencer for the CSIDH-512 reduced-radix (9 limbs × 57-bit) modular-correction ISE datapath.
- Walks limbs 0..8 and drives the combinational datapath's rs1/rs2/imm/op-select each cycle.
- Propagates signed inter-limb carries and streams result limbs to a limb write port.
- Sits between the limb register buffer and the combinational p-limb sub/subadd/andadd datapath.

Parameters:
- NLIMBS, 9, number of limbs processed. Legal range 1..9; the datapath's p-limb table holds 9 entries.
- RADIX, 57, limb radix in bits. Sets the carry extraction position.

Ports:
- g_clk  in  1  clock.
- g_rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- mode  in  1  0 = SUBP (r = a − p); 1 = ADDP (r = a + (mask & p)).
- mask  in  64  ADDP mask; latched at start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the final limb is written.
- sign  out  1  bit 63 of the final top limb; valid with done, held until the next start.
- rd_req  out  1  limb read request.
- rd_idx  out  4  limb read index.
- rd_data  in  64  read data; valid exactly 1 cycle after rd_req.
- wr_en  out  1  result limb write strobe.
- wr_idx  out  4  result limb index.
- wr_data  out  64  result limb.
- dp_rs1  out  64  datapath rs1.
- dp_rs2  out  64  datapath rs2.
- dp_imm  out  4  datapath limb selector.
- dp_op_sub  out  1  datapath op select; tied 0, reserved.
- dp_op_subadd  out  1  datapath op select.
- dp_op_andadd  out  1  datapath op select.
- dp_rd  in  64  datapath result, combinational from the dp_* outputs.

Behaviour:
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches mode and mask, clears carry, sets busy, and issues rd_req with rd_idx=0 the same cycle; → RUN.
  - RUN: one limb per cycle, pipelined. In cycle k (k=1..NLIMBS):
    - compute limb k−1 from rd_data.
    - issue a read of limb k if k < NLIMBS.
  - After limb NLIMBS−1 is written → DONE.
  - DONE: done=1 for one cycle; → IDLE with busy=0.
- Datapath drive while computing limb i (dp_imm=i):
  - SUBP: dp_op_subadd=1, dp_rs1=rd_data, dp_rs2=carry.
  - ADDP: dp_op_andadd=1, dp_rs1=mask_q, dp_rs2=rd_data+carry (64-bit wrap).
  - All dp_op_* are 0 outside RUN.
- Carry and write-back:
  - t = dp_rd.
  - For i < NLIMBS−1: wr_data = zero-extended t[RADIX-1:0]; carry_next = t >>> RADIX (arithmetic, sign-extended to 64).
  - For i = NLIMBS−1: wr_data = t, not reduced; sign = t[63].
  - wr_en=1, wr_idx=i in the compute cycle.
- Latency: start accepted in cycle 0; limb i written in cycle i+1; done in cycle NLIMBS+1 (10 for the defaults).
- start while busy is ignored: no effect on state, mask or mode.
- Reset values: busy=0, done=0, sign=0, rd_req=0, rd_idx=0, wr_en=0, wr_idx=0, wr_data=0, dp_* = 0, carry=0.
- g_rst mid-operation: next cycle is IDLE with the reset values above. No further wr_en. A partially written result is abandoned.
- rd_data is ignored in any cycle not following an rd_req.

Optional Feature:
- Macro: CSIDH_LIMB_SEQ_AUTOCORR_EN.
- Defined:
  - An internal 9×64 result buffer captures every written limb.
  - After a SUBP pass whose top limb has bit 63 = 1, a second ADDP pass runs automatically with mask = all ones, reading from the internal buffer. No rd_req is issued in this pass and there is no read latency bubble.
  - The second pass re-writes limbs 0..8; done and sign come from the second pass.
  - busy stays high across both passes. Total latency is 19 cycles when correction triggers, else 10.
  - The final result is in [0, p) for SUBP inputs in [0, 2p).
- Undefined: no buffer, single pass only. Correction is the caller's job via a separate ADDP start.

Test Plan:
- a = p limbs (0x0181B90533C6C87B … 0x0065B48E8F740F89), SUBP → 9 writes of 0x0; sign=0; done in cycle 10.
- a = 0, SUBP, macro undefined → limb0 = 0x007E46FACC393785, limbs 1..7 each 2^57 − p_i − 1, top limb negative; sign=1.
- a = 0, ADDP, mask = 0xFFFFFFFFFFFFFFFF → writes are exactly the 9 p limbs in order; sign=0. Same with mask = 0 → all-zero writes.
- start pulsed again in cycles 3 and 5 of an operation → ignored; exactly 9 writes and 1 done.
- g_rst asserted in cycle 4 → no wr_en from cycle 5 on; busy=0, done never pulses; a fresh start afterwards completes normally.
- Macro defined, a = 0, SUBP → 18 writes; final 9 writes all 0x0; sign=0; done in cycle 19. Same with a = p → 9 writes, done in cycle 10.

Source files
------------

// File: rtl/csidh_limb_seq.sv
// rtl/csidh_limb_seq.sv - limb sequencer for the CSIDH-512 reduced-radix modular-correction datapath
//
// Walks limbs 0..NLIMBS-1 one per cycle, driving the combinational p-limb
// datapath (dp_*) and streaming reduced result limbs to the write port.
// Signed inter-limb carries are propagated between limbs. The top limb is
// written unreduced and its bit 63 is reported on sign.
//
// Ports:
//   g_clk, g_rst            clock, synchronous active-high reset
//   start, mode, mask       launch (IDLE only); mode 0 = SUBP, 1 = ADDP; ADDP mask
//   busy, done, sign        status; done pulses with the final limb; sign held
//   rd_req, rd_idx, rd_data limb read port (data one cycle after request)
//   wr_en, wr_idx, wr_data  result limb write port
//   dp_rs1, dp_rs2, dp_imm  datapath operands and limb selector
//   dp_op_*                 datapath op selects (dp_op_sub reserved, tied 0)
//   dp_rd                   combinational datapath result
//
// Optional feature macro: CSIDH_LIMB_SEQ_AUTOCORR_EN
//   When defined, a negative SUBP result is corrected by an automatic ADDP
//   pass (mask = all ones) over an internal result buffer.

module csidh_limb_seq #(
  parameter int NLIMBS = 9,
  parameter int RADIX  = 57
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] mask,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic        rd_req,
  output logic [3:0]  rd_idx,
  input  logic [63:0] rd_data,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [63:0] wr_data,
  output logic [63:0] dp_rs1,
  output logic [63:0] dp_rs2,
  output logic [3:0]  dp_imm,
  output logic        dp_op_sub,
  output logic        dp_op_subadd,
  output logic        dp_op_andadd,
  input  logic [63:0] dp_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0]  LAST     = 4'(NLIMBS - 1);
  localparam logic [63:0] LOW_MASK = (64'd1 << RADIX) - 64'd1;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] carry_q, carry_d;
  logic [63:0] mask_q, mask_d;
  logic        mode_q, mode_d;
  logic        sign_q, sign_d;
  logic        second_q, second_d;

  logic [63:0] buf_data;
  logic [63:0] limb_a;
  logic [63:0] t_shift;

`ifdef CSIDH_LIMB_SEQ_AUTOCORR_EN
  localparam bit AUTOCORR = 1'b1;

  // Every written limb is kept so the correction pass can run without
  // touching the external read port.
  logic [63:0] res_buf [NLIMBS];

  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      res_buf[wr_idx] <= wr_data;
    end
  end

  assign buf_data = res_buf[idx_q];
`else
  localparam bit AUTOCORR = 1'b0;

  assign buf_data = 64'h0;
`endif

  // Correction pass sources its limbs from the buffer, first pass from memory.
  assign limb_a  = second_q ? buf_data : rd_data;
  // Signed carry out of the current limb.
  assign t_shift = 64'($signed(dp_rd) >>> RADIX);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    mask_d       = mask_q;
    mode_d       = mode_q;
    sign_d       = sign_q;
    second_d     = second_q;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    rd_req       = 1'b0;
    rd_idx       = 4'd0;
    wr_en        = 1'b0;
    wr_idx       = 4'd0;
    wr_data      = 64'h0;
    dp_rs1       = 64'h0;
    dp_rs2       = 64'h0;
    dp_imm       = 4'd0;
    dp_op_sub    = 1'b0;
    dp_op_subadd = 1'b0;
    dp_op_andadd = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          mask_d   = mask;
          carry_d  = 64'h0;
          idx_d    = 4'd0;
          second_d = 1'b0;
          rd_req   = 1'b1;
          rd_idx   = 4'd0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        dp_imm = idx_q;
        if (mode_q) begin
          dp_op_andadd = 1'b1;
          dp_rs1       = mask_q;
          dp_rs2       = limb_a + carry_q;
        end else begin
          dp_op_subadd = 1'b1;
          dp_rs1       = limb_a;
          dp_rs2       = carry_q;
        end

        wr_en  = 1'b1;
        wr_idx = idx_q;

        if (idx_q != LAST) begin
          wr_data = dp_rd & LOW_MASK;
          carry_d = t_shift;
          idx_d   = idx_q + 4'd1;
          // Read-ahead keeps one limb per cycle; the buffer pass needs none.
          if (!second_q) begin
            rd_req = 1'b1;
            rd_idx = idx_q + 4'd1;
          end
        end else begin
          // Top limb keeps its full width so the sign survives.
          wr_data = dp_rd;
          sign_d  = dp_rd[63];
          if (AUTOCORR && !second_q && !mode_q && dp_rd[63]) begin
            second_d = 1'b1;
            mode_d   = 1'b1;
            mask_d   = {64{1'b1}};
            carry_d  = 64'h0;
            idx_d    = 4'd0;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      carry_q  <= 64'h0;
      mask_q   <= 64'h0;
      mode_q   <= 1'b0;
      sign_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      second_q <= second_d;
    end
  end

  assign sign = sign_q;

endmodule

// File: tb/tb_csidh_limb_seq.sv
// tb/tb_csidh_limb_seq.sv - directed self-checking bench for csidh_limb_seq

module tb_csidh_limb_seq;

  localparam logic [511:0] P = 512'h65b48e8f740f89bf_fc8ab0d15e3e4c4a_b42d083aedc88c42_5afbfcc69322c9cd_a7aac6c567f35507_516730cc1f0b4f25_c2721bf457aca835_1b81b90533c6c87b;

  logic        g_clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [63:0] mask  = 64'h0;
  logic        busy, done, sign, rd_req, wr_en;
  logic [3:0]  rd_idx, wr_idx, dp_imm;
  logic [63:0] rd_data = 64'h0;
  logic [63:0] wr_data, dp_rs1, dp_rs2, dp_rd;
  logic        dp_op_sub, dp_op_subadd, dp_op_andadd;

  always #5 g_clk = ~g_clk;

  csidh_limb_seq dut (
    .g_clk(g_clk), .g_rst(g_rst), .start(start), .mode(mode), .mask(mask),
    .busy(busy), .done(done), .sign(sign),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_imm(dp_imm),
    .dp_op_sub(dp_op_sub), .dp_op_subadd(dp_op_subadd), .dp_op_andadd(dp_op_andadd),
    .dp_rd(dp_rd)
  );

  function automatic logic [63:0] p_limb(input logic [3:0] i);
    logic [511:0] s;
    s = P >> (57 * int'(i));
    if (i == 4'd8) return s[63:0];
    if (i > 4'd8) return 64'h0;
    return {7'b0, s[56:0]};
  endfunction

  // Datapath model: subadd = rs1 - p[imm] + rs2, andadd = (rs1 & p[imm]) + rs2.
  assign dp_rd = dp_op_subadd ? (dp_rs1 - p_limb(dp_imm) + dp_rs2) :
                 dp_op_andadd ? ((dp_rs1 & p_limb(dp_imm)) + dp_rs2) : 64'h0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [63:0] mem [9];
  logic [63:0] exp_w [18];
  logic [63:0] wr_data_log [32];
  logic [3:0]  wr_idx_log [32];
  int          wr_cyc_log [32];
  int          wr_cnt, done_cnt, done_cyc, rdq_cnt;

  task automatic run_op(input logic m, input logic [63:0] msk, input int rst_at,
                        input int pulse_a, input int pulse_b);
    logic       prev_req;
    logic [3:0] prev_idx;
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; rdq_cnt = 0;
    @(posedge g_clk); #1;
    start = 1'b1; mode = m; mask = msk; rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge g_clk);
    check("start_rd_req", {63'h0, rd_req}, 64'd1);
    prev_req = rd_req; prev_idx = rd_idx;
    for (int c = 1; c <= 24; c++) begin
      @(posedge g_clk); #1;
      start   = (c == pulse_a) || (c == pulse_b);
      mode    = start ? ~m : m;
      mask    = start ? ~msk : msk;
      g_rst   = (c == rst_at);
      rd_data = (prev_req && prev_idx < 4'd9) ? mem[prev_idx] : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge g_clk);
      if (wr_en && wr_cnt < 32) begin
        wr_data_log[wr_cnt] = wr_data;
        wr_idx_log[wr_cnt]  = wr_idx;
        wr_cyc_log[wr_cnt]  = c;
        wr_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (rd_req) rdq_cnt++;
      prev_req = rd_req; prev_idx = rd_idx;
    end
    start = 1'b0; g_rst = 1'b0;
  endtask

  task automatic check_result(input string tag, input int n_exp, input int cyc_exp,
                              input logic sign_exp);
    check({tag, "_nwr"}, 64'(wr_cnt), 64'(n_exp));
    for (int i = 0; i < n_exp && i < wr_cnt; i++) begin
      check($sformatf("%s_data%0d", tag, i), wr_data_log[i], exp_w[i]);
      check($sformatf("%s_idx%0d", tag, i), 64'(wr_idx_log[i]), 64'(i % 9));
    end
    check({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(cyc_exp));
    check({tag, "_sign"}, {63'h0, sign}, {63'h0, sign_exp});
    check({tag, "_busy_end"}, {63'h0, busy}, 64'd0);
    check({tag, "_nrdreq"}, 64'(rdq_cnt), 64'd8);
  endtask

  task automatic set_mem_p();
    for (int i = 0; i < 9; i++) mem[i] = p_limb(4'(i));
  endtask

  task automatic set_mem_zero();
    for (int i = 0; i < 9; i++) mem[i] = 64'h0;
  endtask

  task automatic set_exp_zero();
    for (int i = 0; i < 18; i++) exp_w[i] = 64'h0;
  endtask

  task automatic set_exp_negp(input int base);
    exp_w[base] = 64'h007E46FACC393785;
    for (int i = 1; i < 8; i++) exp_w[base + i] = 64'h0200000000000000 - p_limb(4'(i)) - 64'd1;
    exp_w[base + 8] = 64'hFF9A4B71708BF076;
  endtask

  initial begin
    repeat (3) @(posedge g_clk);
    #1 g_rst = 1'b0;
    @(negedge g_clk);
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_sign", {63'h0, sign}, 64'd0);
    check("rst_rd_req", {63'h0, rd_req}, 64'd0);
    check("rst_rd_idx", 64'(rd_idx), 64'd0);
    check("rst_wr_en", {63'h0, wr_en}, 64'd0);
    check("rst_wr_idx", 64'(wr_idx), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_dp_rs1", dp_rs1, 64'd0);
    check("rst_dp_rs2", dp_rs2, 64'd0);
    check("rst_dp_imm", 64'(dp_imm), 64'd0);
    check("rst_dp_ops", {61'h0, dp_op_sub, dp_op_subadd, dp_op_andadd}, 64'd0);

    // a = p, SUBP: exact zero.
    set_mem_p(); set_exp_zero();
    run_op(1'b0, 64'h0, -1, -1, -1);
    check_result("subp_p", 9, 10, 1'b0);

    // a = 0, SUBP: -p in radix form, or corrected to zero by the second pass.
    set_mem_zero(); set_exp_zero(); set_exp_negp(0);
    run_op(1'b0, 64'h0, -1, -1, -1);
`ifdef CSIDH_LIMB_SEQ_AUTOCORR_EN
    check_result("subp_0", 18, 19, 1'b0);
`else
    check_result("subp_0", 9, 10, 1'b1);
`endif

    // a = 0, ADDP with full mask: p limbs.
    set_mem_zero();
    for (int i = 0; i < 9; i++) exp_w[i] = p_limb(4'(i));
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);
    check_result("addp_ones", 9, 10, 1'b0);

    // a = 0, ADDP with zero mask.
    set_exp_zero();
    run_op(1'b1, 64'h0, -1, -1, -1);
    check_result("addp_zero", 9, 10, 1'b0);

    // Manual correction: ADDP of the -p image with carries back to zero.
    set_exp_negp(0);
    for (int i = 0; i < 9; i++) mem[i] = exp_w[i];
    set_exp_zero();
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);
    check_result("addp_corr", 9, 10, 1'b0);

    // a = p with limb0 - 1 and limb1 + 3: borrow into limb1 leaves 2.
    set_mem_p();
    mem[0] = mem[0] - 64'd1;
    mem[1] = mem[1] + 64'd3;
    set_exp_zero();
    exp_w[0] = 64'h01FF_FFFF_FFFF_FFFF;
    exp_w[1] = 64'd2;
    run_op(1'b0, 64'h0, -1, -1, -1);
    check_result("subp_borrow", 9, 10, 1'b0);

    // Stray starts in cycles 3 and 5 with different mode/mask are ignored.
    set_mem_zero();
    for (int i = 0; i < 9; i++) exp_w[i] = p_limb(4'(i));
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 3, 5);
    check_result("restart", 9, 10, 1'b0);

    // Reset in cycle 4 abandons the operation.
    set_mem_p();
    run_op(1'b0, 64'h0, 4, -1, -1);
    check("rst_mid_nwr", 64'(wr_cnt), 64'd4);
    check("rst_mid_last_cyc", 64'(wr_cnt > 0 ? wr_cyc_log[wr_cnt - 1] : -1), 64'd4);
    check("rst_mid_ndone", 64'(done_cnt), 64'd0);
    check("rst_mid_busy", {63'h0, busy}, 64'd0);
    check("rst_mid_sign", {63'h0, sign}, 64'd0);

    // Fresh start after the abort completes normally.
    set_mem_zero();
    for (int i = 0; i < 9; i++) exp_w[i] = p_limb(4'(i));
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);
    check_result("post_rst", 9, 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
